// File: rtl/path_pkg.sv
// Shared types and constants for the path loader and its path memory.
// Move codes, sequencer states and the fixed memory-map addresses.
package path_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0] MV_RIGHT  = 5'd1;
    localparam logic [4:0] MV_UP     = 5'd2;
    localparam logic [4:0] MV_LEFT   = 5'd3;
    localparam logic [4:0] MV_DOWN   = 5'd4;

    localparam logic [4:0] LEN_ADDR  = 5'd31;
    localparam logic [4:0] MAX_MOVES = 5'd31;

endpackage

// File: rtl/path_mem.sv
// 2**AW x DW path register file: one synchronous write port and one
// asynchronous read port that returns zero while the read enable is low.
module path_mem #(
    parameter int DW = 5,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [0:(2**AW)-1];

    // Synchronous write; contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Enable-gated asynchronous read.
    always_comb begin
        rdata = '0;
        if (re) begin
            rdata = mem_r[raddr];
        end else begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/path_loader.sv
// Loads a move sequence into the path memory, then runs one path-sum job on it.
// Optional build macro PATH_LOADER_FILTER_EN drops codes outside 1..4 at load.
module path_loader
    import path_pkg::*;
#(
    parameter int DW = 5,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          mem_en,
    input  logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          ps_clr,
    output logic          start,
    input  logic          fin,
    input  logic [DW-1:0] result,
    output logic [DW-1:0] sum,
    output logic          done,
    output logic          err
);

    state_t        state_r, state_s;
    logic [AW-1:0] wcnt_r, wcnt_s;
    logic          err_r, err_s;
    logic          first_r, first_s;
    logic [DW-1:0] sum_r, sum_s;
    logic          in_ready_r, ps_clr_r, start_r, done_r;

    logic          accept_s, keep_s, fits_s, store_s, ovf_s;
    logic          we_s;
    logic [AW-1:0] waddr_s;
    logic [DW-1:0] wdata_s;

    // in_ready_r is only ever high in LOAD, so it also qualifies the state.
    assign accept_s = in_valid && in_ready_r;
`ifdef PATH_LOADER_FILTER_EN
    assign keep_s   = (in_data >= DW'(MV_RIGHT)) && (in_data <= DW'(MV_DOWN));
`else
    assign keep_s   = 1'b1;
`endif
    assign fits_s   = (wcnt_r != AW'(MAX_MOVES));
    assign store_s  = accept_s && keep_s && fits_s;
    assign ovf_s    = accept_s && keep_s && !fits_s;

    // Single write port: moves during LOAD, the final length during CLR.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = wcnt_r;
        wdata_s = in_data;
        if (state_r == CLR) begin
            we_s    = 1'b1;
            waddr_s = AW'(LEN_ADDR);
            wdata_s = DW'(wcnt_r);
        end else begin
            we_s    = store_s;
            waddr_s = wcnt_r;
            wdata_s = in_data;
        end
    end

    path_mem #(.DW(DW), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .re    (mem_en),
        .raddr (mem_addr),
        .rdata (mem_data)
    );

    // Next-state and datapath updates for the job sequencer.
    always_comb begin
        state_s = state_r;
        wcnt_s  = wcnt_r;
        err_s   = err_r;
        first_s = first_r;
        sum_s   = sum_r;
        case (state_r)
            LOAD: begin
                if (accept_s) begin
                    first_s = 1'b0;
                    // First beat of a new sequence drops the previous job's error.
                    err_s   = first_r ? ovf_s : (err_r | ovf_s);
                    if (store_s) begin
                        wcnt_s = wcnt_r + AW'(1);
                    end else begin
                        wcnt_s = wcnt_r;
                    end
                    if (in_last) begin
                        state_s = CLR;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            CLR: begin
                state_s = RUN;
            end
            RUN: begin
                if (fin) begin
                    sum_s   = result;
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                wcnt_s  = '0;
                first_s = 1'b1;
                state_s = LOAD;
            end
            default: begin
                state_s = LOAD;
            end
        endcase
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= LOAD;
            wcnt_r  <= '0;
            err_r   <= 1'b0;
            first_r <= 1'b1;
            sum_r   <= '0;
        end else begin
            state_r <= state_s;
            wcnt_r  <= wcnt_s;
            err_r   <= err_s;
            first_r <= first_s;
            sum_r   <= sum_s;
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r <= 1'b1;
            ps_clr_r   <= 1'b0;
            start_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= (state_s == LOAD);
            ps_clr_r   <= (state_s == CLR);
            start_r    <= (state_s == RUN);
            done_r     <= (state_s == DONE);
        end
    end

    assign in_ready = in_ready_r;
    assign ps_clr   = ps_clr_r;
    assign start    = start_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign err      = err_r;

endmodule
